// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants for the EX-stage issue unit.
//   - ALU control codes driven on alu_ctl (AND/OR/ADD/SUB/NOR).
//   - ALUOp encodings coming from ID.
//   - R-type funct values recognised by the control decoder.
//   - sext16: sign extension of a 16-bit immediate to 32 bits.
package alu_issue_pkg;

  // ALU control codes understood by the combinational ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // ALUOp field from ID
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,  // lw/sw address
    ALUOP_SUB   = 2'b01,  // beq compare
    ALUOP_RTYPE = 2'b10,  // use funct
    ALUOP_ILL   = 2'b11
  } aluop_e;

  // R-type funct values
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_ctl_dec.sv
// alu_ctl_dec: combinational ALUOp/funct -> ALU control translation.
// Ports:
//   alu_op  in  2   ALUOp from ID
//   funct   in  6   R-type funct
//   ctl     out 4   ALU control code (ADD when illegal)
//   illegal out 1   unsupported ALUOp or funct
import alu_issue_pkg::*;

module alu_ctl_dec (
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] ctl,
  output logic       illegal
);

  always_comb begin
    ctl     = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: ctl = ALU_ADD;
      ALUOP_SUB: ctl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: ctl = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: ctl = ALU_SUB;
          FUNCT_AND:             ctl = ALU_AND;
          FUNCT_OR:              ctl = ALU_OR;
          FUNCT_NOR:             ctl = ALU_NOR;
          default:               illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: EX-stage issue unit in front of a combinational ALU.
// Two register stages: E (drives the ALU) and M (captures the ALU result,
// feeds MEM). One instruction per cycle with full backpressure.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          ID -> EX handshake
//   in_alu_op, in_funct        operation select
//   in_rs_val, in_rt_val       register-file operands
//   in_rs_idx, in_rt_idx       source indices (used only with forwarding)
//   in_imm, in_alu_src         immediate and B-operand select
//   in_wr, in_dest             destination write enable / index
//   alu_ctl, alu_a, alu_b      registered ALU inputs
//   alu_res, alu_zero          ALU outputs
//   out_valid/out_ready        EX -> MEM handshake
//   out_res, out_zero, out_illegal, out_wr, out_dest   result stage
// Build option: define ALU_ISSUE_FWD_EN to forward results from E/M into
// the operands of a newly accepted instruction.
import alu_issue_pkg::*;

module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_alu_op,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  input  logic [4:0]  in_rs_idx,
  input  logic [4:0]  in_rt_idx,
  input  logic [15:0] in_imm,
  input  logic        in_alu_src,
  input  logic        in_wr,
  input  logic [4:0]  in_dest,
  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_res,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic        out_zero,
  output logic        out_illegal,
  output logic        out_wr,
  output logic [4:0]  out_dest
);

  logic        e_valid_reg, e_wr_reg, e_illegal_reg;
  logic [4:0]  e_dest_reg;
  logic [3:0]  e_ctl_reg;
  logic [31:0] e_a_reg, e_b_reg;

  logic        m_valid_reg, m_zero_reg, m_wr_reg, m_illegal_reg;
  logic [4:0]  m_dest_reg;
  logic [31:0] m_res_reg;

  logic        m_adv, e_adv, accept;
  logic [3:0]  dec_ctl;
  logic        dec_illegal;
  logic [31:0] a_next, rt_next, b_next;

  alu_ctl_dec u_dec (
    .alu_op  (in_alu_op),
    .funct   (in_funct),
    .ctl     (dec_ctl),
    .illegal (dec_illegal)
  );

  assign m_adv    = !m_valid_reg || out_ready;
  assign e_adv    = !e_valid_reg || m_adv;
  assign in_ready = e_adv;
  assign accept   = in_valid && e_adv;

`ifdef ALU_ISSUE_FWD_EN
  // E result is still on the ALU outputs, so it is the youngest source.
  always_comb begin
    a_next  = in_rs_val;
    rt_next = in_rt_val;
    if (in_rs_idx != 5'd0 && e_valid_reg && e_wr_reg && e_dest_reg == in_rs_idx)
      a_next = alu_res;
    else if (in_rs_idx != 5'd0 && m_valid_reg && m_wr_reg && m_dest_reg == in_rs_idx)
      a_next = m_res_reg;
    if (in_rt_idx != 5'd0 && e_valid_reg && e_wr_reg && e_dest_reg == in_rt_idx)
      rt_next = alu_res;
    else if (in_rt_idx != 5'd0 && m_valid_reg && m_wr_reg && m_dest_reg == in_rt_idx)
      rt_next = m_res_reg;
  end
`else
  logic unused_idx;
  assign unused_idx = ^{in_rs_idx, in_rt_idx};
  assign a_next  = in_rs_val;
  assign rt_next = in_rt_val;
`endif

  assign b_next = in_alu_src ? sext16(in_imm) : rt_next;

  // E stage: loads on accept; otherwise empties once its content moved on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid_reg   <= 1'b0;
      e_ctl_reg     <= ALU_ADD;
      e_a_reg       <= '0;
      e_b_reg       <= '0;
      e_wr_reg      <= 1'b0;
      e_dest_reg    <= '0;
      e_illegal_reg <= 1'b0;
    end else if (accept) begin
      e_valid_reg   <= 1'b1;
      e_ctl_reg     <= dec_ctl;
      e_a_reg       <= a_next;
      e_b_reg       <= b_next;
      e_wr_reg      <= in_wr && !dec_illegal;
      e_dest_reg    <= in_dest;
      e_illegal_reg <= dec_illegal;
    end else if (e_adv) begin
      e_valid_reg   <= 1'b0;
    end
  end

  // M stage: moves only when MEM can take its content (or it is empty).
  // Data fields load only for a real instruction so an idle pipe holds
  // the last result rather than re-sampling a stale ALU output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_reg   <= 1'b0;
      m_res_reg     <= '0;
      m_zero_reg    <= 1'b0;
      m_wr_reg      <= 1'b0;
      m_dest_reg    <= '0;
      m_illegal_reg <= 1'b0;
    end else if (m_adv) begin
      m_valid_reg <= e_valid_reg;
      if (e_valid_reg) begin
        m_res_reg     <= alu_res;
        m_zero_reg    <= alu_zero;
        m_wr_reg      <= e_wr_reg;
        m_dest_reg    <= e_dest_reg;
        m_illegal_reg <= e_illegal_reg;
      end
    end
  end

  assign alu_ctl     = e_ctl_reg;
  assign alu_a       = e_a_reg;
  assign alu_b       = e_b_reg;
  assign out_valid   = m_valid_reg;
  assign out_res     = m_res_reg;
  assign out_zero    = m_zero_reg;
  assign out_illegal = m_illegal_reg;
  assign out_wr      = m_wr_reg;
  assign out_dest    = m_dest_reg;

endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage issue unit that drives the combinational ALU's `ctl`/`data_1`/`data_2` interface and captures its `res`/`zero` outputs. It accepts decoded instruction fields from ID over a valid/ready handshake and translates ALUOp/funct into the 4-bit ALU control codes from `alu_ops.vh`. It selects operands, registers them into an issue stage, and registers the ALU result into a result stage feeding MEM. It provides one instruction per cycle throughput with full backpressure.

## Interface
- No parameters; widths fixed (32-bit data, 5-bit register index, 4-bit ctl).
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid` / `in_ready`  in / out  1  ID→EX handshake.
- `in_alu_op`  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type (use funct), 11 illegal.
- `in_funct`  in  6  R-type funct.
- `in_rs_val`, `in_rt_val`  in  32  register-file operands.
- `in_rs_idx`, `in_rt_idx`  in  5  source indices (forwarding only).
- `in_imm`  in  16  immediate, sign-extended.
- `in_alu_src`  in  1  1: B = sext(imm), 0: B = rt_val.
- `in_wr`, `in_dest`  in  1, 5  result writes register `in_dest`.
- `alu_ctl`  out  4; `alu_a`, `alu_b`  out  32  registered, to ALU.
- `alu_res`  in  32; `alu_zero`  in  1  from ALU.
- `out_valid` / `out_ready`  out / in  1  EX→MEM handshake.
- `out_res`  out  32; `out_zero`, `out_illegal`, `out_wr`  out  1; `out_dest`  out  5.

## Operation
- Two register stages: E (issue: ctl, A, B, wr, dest, illegal, e_valid) and M (result: res, zero, wr, dest, illegal, m_valid).
- Decode: alu_op 00→`ADD`, 01→`SUB`. For 10, funct 100000/100001→`ADD`, 100010/100011→`SUB`, 100100→`AND`, 100101→`OR`, 100111→`NOR`. Any other funct, or alu_op 11, sets illegal, ctl=`ADD`, and forces wr=0.
- Handshake: m_adv = !m_valid | out_ready; e_adv = !e_valid | m_adv; in_ready = e_adv (combinational). Transfer only when valid & ready both high.
- On E advance, M loads alu_res/alu_zero plus E sideband; m_valid ← e_valid. On input accept, E loads; otherwise e_valid clears if E advanced.
- Stalled stages hold all contents unchanged; ALU inputs stay stable while E is stalled.
- `out_*` mirror M registers directly.

## Timing
- Reset: e_valid=m_valid=0, in_ready=1, `alu_ctl`=`ADD`, `alu_a`=`alu_b`=0, `out_res`=0, `out_zero`=0, `out_illegal`=0, `out_wr`=0, `out_dest`=0. Reset asserted mid-operation discards in-flight instructions immediately.
- Latency: accepted at edge N → drives ALU after N, `out_valid` high after edge N+1.
- Throughput 1/cycle with out_ready held high. Two instructions buffered max; in_ready falls the cycle both stages hold data and out_ready is low.
- Simultaneous out handshake and input accept while full: both complete in the same cycle, no bubble.
- Arithmetic: no overflow trap; add/addu identical, wrap modulo 2^32.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: on accept, A (and B when alu_src=0) is forwarded when the matching index is nonzero. Priority 1: E holds wr=1 and dest=idx, using live `alu_res`. Priority 2: M holds m_valid, wr=1 and dest=idx, using `out_res`. Otherwise the register-file value is used.
- Undefined: operands come only from in_rs_val/in_rt_val; idx ports are ignored.

## Structure
- Extend `alu_ops.vh` with ALUOp codes (`ALUOP_ADD`, `ALUOP_SUB`, `ALUOP_RTYPE`) and funct constants; ctl codes stay there.
- Sub-module `alu_ctl_dec`: combinational alu_op/funct → ctl + illegal.

## Test plan
- add: alu_op=10, funct=100000, rs=5, rt=7 → out_res=12, out_zero=0, out_wr=1, out_valid one cycle after E load.
- beq: alu_op=01, rs=rt=0x9 → out_res=0, out_zero=1.
- lw address: alu_op=00, rs=0x1000, imm=0xFFFC, alu_src=1 → out_res=0x00000FFC.
- Backpressure: 3 back-to-back inputs, out_ready low 3 cycles → in_ready low after 2 accepts; results later emerge in order, none lost or duplicated.
- Illegal: alu_op=10, funct=001000 → out_illegal=1, out_wr=0; next valid instruction unaffected.
- Forwarding: add r3=1+2, then sub rs_idx=3 (rs_val=0), rt=1 → out_res=2 with `ALU_ISSUE_FWD_EN`, 0xFFFFFFFF without.
